debug_unit: RTL and testbench

DEBUG_UNIT -- requirements
Module: debug_unit

---
 rtl/debug_unit.sv | 141 ++++++++++++++
 tb/tb_debug_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// rtl/debug_unit.sv - host-driven debug controller: run/step/halt, pipeline reset, state dump
// Optional feature macro: DEBUG_MEM_DUMP_EN appends data memory words 0..9 to the dump.
module debug_unit #(
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          clkEnable,
  output logic          pipeReset,
  input  logic [31:0]   instruction,
  input  logic [9:0]    PC_IFID,
  input  logic [1023:0] Registers,
  input  logic [319:0]  Memorias,
  output logic          busy
);

  localparam logic [7:0] CMD_RUN   = 8'h63;
  localparam logic [7:0] CMD_STEP  = 8'h73;
  localparam logic [7:0] CMD_RESET = 8'h72;
  localparam logic [7:0] CMD_DUMP  = 8'h64;
  localparam logic [7:0] CMD_PAUSE = 8'h70;

`ifdef DEBUG_MEM_DUMP_EN
  localparam logic [7:0] LAST_BYTE = 8'd169;
  localparam int         NWORDS    = 42;
  logic [NWORDS*32-1:0] words;
  assign words = {Memorias, Registers};
`else
  localparam logic [7:0] LAST_BYTE = 8'd129;
  localparam int         NWORDS    = 32;
  logic [NWORDS*32-1:0] words;
  logic                 unused_mem;
  assign words      = Registers;
  assign unused_mem = ^Memorias;
`endif

  localparam int IW = $clog2(NWORDS);

  typedef enum logic [2:0] {IDLE, RUN, STEP, DUMP, PRST} state_t;

  state_t        state, next_state;
  logic [7:0]    cnt, next_cnt;
  logic [7:0]    off;
  logic [IW-1:0] word_idx;
  logic [31:0]   word;
  logic [7:0]    lane_byte;

  // Dump payload bytes start at count 2, after the two PC bytes.
  assign off      = cnt - 8'd2;
  assign word_idx = IW'(off >> 2);
  assign busy     = (state != IDLE);

  // Select the 32-bit word currently being dumped.
  always_comb begin
    word = '0;
    for (int i = 0; i < NWORDS; i++) begin
      if (word_idx == i[IW-1:0]) word = words[i*32 +: 32];
    end
  end

  // Pick the byte within the word, most-significant byte first.
  always_comb begin
    lane_byte = 8'h00;
    case (off[1:0])
      2'd0: lane_byte = word[31:24];
      2'd1: lane_byte = word[23:16];
      2'd2: lane_byte = word[15:8];
      2'd3: lane_byte = word[7:0];
      default: lane_byte = 8'h00;
    endcase
  end

  // Outgoing byte; inputs are read live because the pipeline is frozen while dumping.
  always_comb begin
    tx_data = 8'h00;
    if (tx_valid) begin
      if (cnt == 8'd0)      tx_data = {6'b0, PC_IFID[9:8]};
      else if (cnt == 8'd1) tx_data = PC_IFID[7:0];
      else                  tx_data = lane_byte;
    end
  end

  // Next-state and counter logic; the counter restarts on every state change.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_RUN:   next_state = RUN;
            CMD_STEP:  next_state = STEP;
            CMD_RESET: next_state = PRST;
            CMD_DUMP:  next_state = DUMP;
            default:   next_state = IDLE;
          endcase
        end
      end
      RUN: begin
        if ((instruction == HALT_WORD) || (rx_valid && rx_data == CMD_PAUSE))
          next_state = DUMP;
      end
      STEP: next_state = DUMP;
      PRST: begin
        if (cnt == 8'd1) next_state = IDLE;
        else             next_cnt   = cnt + 8'd1;
      end
      DUMP: begin
        if (tx_valid && tx_ready) begin
          if (cnt == LAST_BYTE) next_state = IDLE;
          else                  next_cnt   = cnt + 8'd1;
        end
      end
      default: next_state = IDLE;
    endcase
    if (next_state != state) next_cnt = 8'd0;
  end

  // State, counter and registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      clkEnable <= 1'b0;
      pipeReset <= 1'b0;
      tx_valid  <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      clkEnable <= (next_state == RUN) || (next_state == STEP);
      pipeReset <= (next_state == PRST);
      tx_valid  <= (next_state == DUMP);
    end
  end

endmodule

// File: tb/tb_debug_unit.sv
// tb/tb_debug_unit.sv - self-checking bench for debug_unit
module tb_debug_unit;

  localparam logic [31:0] HALT = 32'hFFFFFFFF;
`ifdef DEBUG_MEM_DUMP_EN
  localparam int NBYTES = 170;
`else
  localparam int NBYTES = 130;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          clkEnable;
  logic          pipeReset;
  logic [31:0]   instruction = 32'h0;
  logic [9:0]    PC_IFID = 10'h0;
  logic [1023:0] Registers = '0;
  logic [319:0]  Memorias = '0;
  logic          busy;

  int total = 0;
  int bad = 0;

  logic [31:0] regs_m[32];
  logic [31:0] mem_m[10];
  logic [9:0]  pc_m;
  byte unsigned exp_q[$];

  debug_unit #(.HALT_WORD(HALT)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .clkEnable(clkEnable), .pipeReset(pipeReset), .instruction(instruction),
    .PC_IFID(PC_IFID), .Registers(Registers), .Memorias(Memorias), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic randomize_state();
    pc_m = 10'($urandom);
    for (int i = 0; i < 32; i++) regs_m[i] = $urandom;
    for (int i = 0; i < 10; i++) mem_m[i] = $urandom;
  endtask

  task automatic apply_state();
    PC_IFID = pc_m;
    for (int i = 0; i < 32; i++) Registers[i*32 +: 32] = regs_m[i];
    for (int i = 0; i < 10; i++) Memorias[i*32 +: 32] = mem_m[i];
  endtask

  // Expected dump stream built straight from the byte-order rules.
  task automatic build_expected();
    exp_q.delete();
    exp_q.push_back(byte'(pc_m >> 8));
    exp_q.push_back(byte'(pc_m & 10'hFF));
    for (int r = 0; r < 32; r++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(byte'(regs_m[r] >> (8 * b)));
`ifdef DEBUG_MEM_DUMP_EN
    for (int m = 0; m < 10; m++)
      for (int b = 3; b >= 0; b--) exp_q.push_back(byte'(mem_m[m] >> (8 * b)));
`endif
  endtask

  // Present a command byte for one edge; returns at the negedge after that edge.
  task automatic send_cmd(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // mode 0: always ready, 1: toggling, 2: random. Entered at a negedge with tx_valid expected high.
  task automatic collect_dump(input int mode, input int stop_after);
    int idx = 0;
    int cyc = 0;
    logic rdy;
    build_expected();
    while (idx < NBYTES && idx < stop_after && cyc < 2000) begin
      chk("tx_valid_continuous", tx_valid, 1'b1);
      if (!tx_valid) break;
      chk($sformatf("dump_byte_%0d", idx), tx_data, exp_q[idx]);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      tx_ready = rdy;
      @(negedge clk);
      if (rdy) idx++;
      cyc++;
    end
    tx_ready = 1'b1;
    if (stop_after >= NBYTES) begin
      chk("dump_byte_count", idx, NBYTES);
      chk("tx_valid_after_dump", tx_valid, 1'b0);
      chk("busy_after_dump", busy, 1'b0);
    end else begin
      chk("partial_byte_count", idx, stop_after);
    end
  endtask

  initial begin
    int ce_cnt;
    int pr_cnt;
    int tv_seen;

    // Reset state
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_clkEnable", clkEnable, 1'b0);
    chk("rst_pipeReset", pipeReset, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Unknown command in IDLE is ignored
    send_cmd(8'h41);
    chk("junk_busy", busy, 1'b0);
    chk("junk_clkEnable", clkEnable, 1'b0);
    @(negedge clk);
    chk("junk_busy2", busy, 1'b0);
    chk("junk_tx_valid", tx_valid, 1'b0);

    // Single step: one clkEnable pulse, then a full dump
    randomize_state();
    pc_m = 10'h004;
    regs_m[1] = 32'h00000005;
    apply_state();
    send_cmd(8'h73);
    chk("step_clkEnable", clkEnable, 1'b1);
    chk("step_tx_valid_early", tx_valid, 1'b0);
    chk("step_busy", busy, 1'b1);
    @(negedge clk);
    chk("step_clkEnable_off", clkEnable, 1'b0);
    chk("step_tx_valid", tx_valid, 1'b1);
    chk("step_byte0", tx_data, 8'h00);
    collect_dump(0, NBYTES);

    // Run until halt word after 7 run cycles, then dump with toggling ready
    randomize_state();
    mem_m[0] = 32'hDEADBEEF;
    apply_state();
    instruction = 32'h0;
    send_cmd(8'h63);
    ce_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (clkEnable) ce_cnt++;
      chk("run_tx_valid_low", tx_valid, 1'b0);
      if (i == 6) instruction = HALT;
      @(negedge clk);
    end
    instruction = 32'h0;
    chk("run_ce_cycles", ce_cnt, 7);
    chk("halt_clkEnable_off", clkEnable, 1'b0);
    chk("halt_tx_valid", tx_valid, 1'b1);
    collect_dump(1, NBYTES);

    // Pipeline reset: two cycles of pipeReset, no dump
    send_cmd(8'h72);
    pr_cnt = 0;
    tv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (pipeReset) pr_cnt++;
      if (tx_valid) tv_seen++;
      chk("prst_clkEnable", clkEnable, 1'b0);
      @(negedge clk);
    end
    chk("prst_cycles", pr_cnt, 2);
    chk("prst_no_tx", tv_seen, 0);
    chk("prst_busy_after", busy, 1'b0);

    // 's' ignored during RUN, 'p' pauses into DUMP
    randomize_state();
    apply_state();
    send_cmd(8'h63);
    @(negedge clk);
    send_cmd(8'h73);
    @(negedge clk);
    chk("run_ignore_s_ce", clkEnable, 1'b1);
    chk("run_ignore_s_tx", tx_valid, 1'b0);
    send_cmd(8'h70);
    chk("pause_clkEnable", clkEnable, 1'b0);
    chk("pause_tx_valid", tx_valid, 1'b1);
    collect_dump(2, NBYTES);

    // 'p' and halt word on the same edge yield a single dump
    randomize_state();
    apply_state();
    send_cmd(8'h63);
    @(negedge clk);
    instruction = HALT;
    send_cmd(8'h70);
    instruction = 32'h0;
    chk("ph_tx_valid", tx_valid, 1'b1);
    collect_dump(0, NBYTES);
    tv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (tx_valid || busy) tv_seen++;
      @(negedge clk);
    end
    chk("ph_single_dump", tv_seen, 0);

    // 'd' from IDLE dumps directly
    randomize_state();
    apply_state();
    send_cmd(8'h64);
    chk("d_tx_valid", tx_valid, 1'b1);
    chk("d_clkEnable", clkEnable, 1'b0);
    collect_dump(2, NBYTES);

    // Reset after 50 bytes aborts, then a fresh dump from byte 0
    randomize_state();
    apply_state();
    send_cmd(8'h73);
    @(negedge clk);
    collect_dump(0, 50);
    reset = 1'b0;
    #1;
    chk("abort_tx_valid", tx_valid, 1'b0);
    chk("abort_tx_data", tx_data, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_clkEnable", clkEnable, 1'b0);
    @(negedge clk);
    chk("abort_hold_tx_valid", tx_valid, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("released_idle", busy, 1'b0);
    send_cmd(8'h73);
    chk("fresh_step_ce", clkEnable, 1'b1);
    @(negedge clk);
    chk("fresh_tx_valid", tx_valid, 1'b1);
    collect_dump(0, NBYTES);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
